// File: rtl/sysbus_pkg.sv
// Shared encodings, sizes and types for the Sysbus line-transfer protocol.
package sysbus_pkg;

    localparam int unsigned TAG_W      = 13;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned LINE_BEATS = 8;
    localparam int unsigned LINE_BYTES = 64;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [3:0] DEV_MEMORY = 4'b0001;
    localparam logic [3:0] DEV_MMIO   = 4'b0011;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACK   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ACK   = S_ACK,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP,
        ST_WDATA = S_WDATA
    } state_e;

    typedef struct packed {
        logic       rw;
        logic [3:0] device;
        logic [7:0] id;
    } tag_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port synchronous word array with one-cycle registered read.
module sysbus_mem_array
    import sysbus_pkg::*;
#(
    parameter int unsigned DEPTH = 8192,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on a read, so a stalled consumer sees a stable word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: acks a line request, then streams eight read
// beats or absorbs eight write beats against an on-chip word array.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 8192,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqcyc,
    input  logic [63:0]       req,
    input  logic [TAG_W-1:0]  reqtag,
    output logic              reqack,
    output logic              respcyc,
    output logic [63:0]       resp,
    output logic [TAG_W-1:0]  resptag,
    input  logic              respack,
    output logic              oob_err
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
    localparam int unsigned BEAT_W = $clog2(LINE_BEATS);

    state_e             state_q, state_d;
    logic [AW-1:0]      base_q, base_d;
    logic               oob_line_q, oob_line_d;
    logic               rw_q, rw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               reqack_q, reqack_d;
    logic               respcyc_q, respcyc_d;
    logic [63:0]        resp_q, resp_d;
    logic [TAG_W-1:0]   resptag_q, resptag_d;
    logic               oob_err_q, oob_err_d;

    logic               ram_re, ram_we;
    logic [AW-1:0]      ram_addr;
    logic [63:0]        ram_wdata, ram_rdata;

    tag_t               req_tag;
    logic [AW-1:0]      req_base_c;
    logic               req_oob_c;

    assign req_tag    = tag_t'(reqtag);
    assign req_base_c = req[AW+2:3] & ~AW'(LINE_BEATS - 1);
    assign req_oob_c  = |req[63:AW+3];

    sysbus_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Reads run one word ahead: resp holds beat N while the array holds N+1
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        oob_line_d = oob_line_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        reqack_d   = 1'b0;
        respcyc_d  = respcyc_q;
        resp_d     = resp_q;
        resptag_d  = resptag_q;
        oob_err_d  = oob_err_q;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = base_q | AW'(beat_q);
        ram_wdata  = req;

        case (state_q)
            ST_IDLE: begin
                if (reqcyc && req_tag.device == DEV_MEMORY) begin
                    state_d    = ST_ACK;
                    base_d     = req_base_c;
                    oob_line_d = req_oob_c;
                    rw_d       = req_tag.rw;
                    resptag_d  = reqtag;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    beat_d     = '0;
                    reqack_d   = 1'b1;
                    oob_err_d  = oob_err_q | req_oob_c;
                    // with a single-cycle latency beat 0 must be fetched now
                    if (LATENCY == 1 && req_tag.rw == RW_READ) begin
                        ram_re   = 1'b1;
                        ram_addr = req_base_c;
                    end
                end
            end

            ST_ACK, ST_WAIT: begin
                if (rw_q == RW_WRITE) begin
                    state_d = ST_WDATA;
                    beat_d  = '0;
                end else if (cnt_q == '0) begin
                    ram_re    = 1'b1;
                    ram_addr  = base_q | AW'(1);
                    state_d   = ST_RESP;
                    respcyc_d = 1'b1;
                    resp_d    = oob_line_q ? 64'h0 : ram_rdata;
                    beat_d    = '0;
                end else begin
                    if (cnt_q == CNT_W'(1)) begin
                        ram_re   = 1'b1;
                        ram_addr = base_q;
                    end
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end

            ST_RESP: begin
                if (respack) begin
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        state_d   = ST_IDLE;
                        respcyc_d = 1'b0;
                    end else begin
                        beat_d   = beat_q + BEAT_W'(1);
                        resp_d   = oob_line_q ? 64'h0 : ram_rdata;
                        ram_re   = 1'b1;
                        ram_addr = base_q | AW'(BEAT_W'(beat_q + BEAT_W'(2)));
                    end
                end
            end

            ST_WDATA: begin
                if (reqcyc) begin
                    ram_we   = ~oob_line_q;
                    reqack_d = 1'b1;
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            oob_line_q <= 1'b0;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            beat_q     <= '0;
            reqack_q   <= 1'b0;
            respcyc_q  <= 1'b0;
            resp_q     <= '0;
            resptag_q  <= '0;
            oob_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            oob_line_q <= oob_line_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            reqack_q   <= reqack_d;
            respcyc_q  <= respcyc_d;
            resp_q     <= resp_d;
            resptag_q  <= resptag_d;
            oob_err_q  <= oob_err_d;
        end
    end

    assign reqack  = reqack_q;
    assign respcyc = respcyc_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;
    assign oob_err = oob_err_q;

endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the Sysbus line-transfer protocol driven by the core's fetch unit. It accepts a 64-byte-line read or write request, acknowledges it, and then either streams eight 64-bit response beats or absorbs eight write-data beats. It is backed by an on-chip word array and is used as the memory model for core bring-up and as the template for the real memory controller front end.

## Interface
- DEPTH, 8192, number of 64-bit words in the backing array; power of two, at least 8.
- LATENCY, 4, cycles from the reqack pulse to the first read beat; minimum 1.
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- reqcyc  in  1  request or write-data beat valid.
- req  in  64  byte address on the request cycle, data on write-data beats.
- reqtag  in  13  {rw[12] (1=READ, 0=WRITE), device[11:8], id[7:0]}.
- reqack  out  1  one-cycle acknowledge of a request cycle or write beat.
- respcyc  out  1  read-response beat valid.
- resp  out  64  read-response data.
- resptag  out  13  copy of the accepted reqtag.
- respack  in  1  initiator accepts the current beat.
- oob_err  out  1  sticky flag; set when an out-of-range line is accessed.

## Operation
- States: IDLE, ACK, WAIT, RESP, WDATA.
- IDLE: if reqcyc=1 and device=MEMORY (4'b0001), latch line base = req & ~63, latch the tag and the rw bit, then go to ACK. Requests for other devices are ignored, with no ack, and the state stays IDLE.
- ACK: reqack=1 for exactly one cycle. A READ goes to WAIT with the latency counter at LATENCY-1. A WRITE goes to WDATA with the beat counter at 0.
- WAIT: the counter decrements each cycle. At 0, issue the array read of beat 0 and go to RESP.
- RESP: respcyc=1, resp = word[base/8 + beat], resptag = the latched tag.
  - Each cycle with respack=1 advances the beat and prefetches the next word, so back-to-back beats run one per cycle.
  - While respack=0, respcyc, resp and resptag hold their values.
  - Acceptance of beat 7 returns to IDLE.
- WDATA: each cycle with reqcyc=1 writes req into word[base/8 + beat], pulses reqack in the next cycle and advances the beat. A cycle with reqcyc=0 is a stall. The 8th accepted beat returns to IDLE.
- Beats always run from the line base, offset 0 through 7; there is no critical-word-first ordering.
- Word index = address[$clog2(DEPTH)+2:3].
- A line is out of range when the bits above that index are non-zero:
  - reads return 64'h0 for all 8 beats;
  - writes are acked but dropped;
  - in both cases oob_err is set and held until reset.
- A reqcyc arriving outside IDLE or WDATA is not acked. The initiator must hold it.

## Timing
- Reset values: reqack=0, respcyc=0, resp=0, resptag=0, oob_err=0, state=IDLE, counters=0.
- Reset asserted mid-transfer aborts immediately. The next request after deassertion is served normally.
- Request with reqcyc at cycle T gives reqack at T+1.
- A read's first respcyc comes at T+1+LATENCY. The last beat comes at T+LATENCY+8 when respack is continuous.
- A write's beat ack comes one cycle after its data cycle. A new request can be accepted in the cycle after the final write ack or the final read beat.
- reqack and respcyc are never high in the same cycle.
- All outputs are registered.

## Structure
- sysbus_pkg holds:
  - the READ/WRITE encodings;
  - the device codes: MEMORY=4'b0001, MMIO=4'b0011;
  - TAG_W=13, LINE_BEATS=8, LINE_BYTES=64;
  - the state enum.
- Sub-module sysbus_mem_array: single-port synchronous RAM, DEPTH x 64, one-cycle read latency, with write enable. It has no reset; its contents are preloaded via $readmemh by the bench.

## Test plan
- Array preloaded word[i]=i*0x0101010101010101; READ at 0x1000, tag id 0x00, respack=respcyc -> reqack at T+1; 8 beats starting T+5 with resp = words 0x200 to 0x207; resptag=0x1100.
- READ at 0x1028 (unaligned) -> beats start from 0x1000, same data as the previous case.
- READ with respack low for 3 cycles on beat 2 -> beat 2 data and respcyc held; no beat skipped or repeated; total 11 respcyc cycles.
- WRITE at 0x40 with data 0xA0 to 0xA7, including one reqcyc-low stall, followed by a READ at 0x40 -> 8 write acks; the read returns 0xA0 to 0xA7 in order.
- READ at 0x1_0000_0000 -> 8 beats of zero; oob_err=1 and held; a device=MMIO request -> no reqack within 20 cycles.
- Reset asserted during beat 4 of a read -> respcyc=0 immediately; after release, a READ at 0x0 returns the correct words 0 to 7.
